rpu_rcv_rsp_queue: RTL and testbench

Buffers receive-completion events (destination tile, packet ID) raised by the RPU receive path. Drains them in order as encoded receive-packet-ID response commands on the XOCC command channel. Sits directly upstream of the XOCC command arbiter. Absorbs command-channel backpressure so the receive datapath never stalls on a single blocked response.

---
 rtl/rpu_rcv_rsp_queue.sv | 140 ++++++++++++++
 tb/tb_rpu_rcv_rsp_queue.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rpu_rcv_rsp_queue.sv
// rpu_rcv_rsp_queue
// In-order queue of receive-completion events {pkt_id, dst_tile_id}. The
// head entry is emitted as a receive-packet-ID response command on the XOCC
// command channel. The queue soaks up command-channel backpressure so that
// the receive datapath keeps moving while a response is blocked.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both high. rcv_rdy and cmd_vld come only from the registered occupancy
// count, so neither depends combinationally on rcv_vld or cmd_rdy. Once
// cmd_vld is high, cmd_out holds until the pop.
//
// Optional build macro NOU_RCV_RSP_STAT_EN adds two outputs:
//   rsp_sent_cnt : saturating count of popped commands
//   q_full_seen  : sticky flag, set once the queue has been full
//
// Default field widths are provided below. A surrounding build that already
// defines these macros takes precedence.

`ifndef NOU_TILE_ID_WIDTH
`define NOU_TILE_ID_WIDTH 8
`endif
`ifndef NOU_PKT_ID_WIDTH
`define NOU_PKT_ID_WIDTH 8
`endif
`ifndef NOU_XOCC_CMD_WIDTH
`define NOU_XOCC_CMD_WIDTH 64
`endif
`ifndef RCV_PKT_RID_RSP_TYPE
`define RCV_PKT_RID_RSP_TYPE 4'h6
`endif

module rpu_rcv_rsp_queue #(
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [`NOU_TILE_ID_WIDTH-1:0]   local_tile_id,
  input  logic                            rcv_vld,
  output logic                            rcv_rdy,
  input  logic [`NOU_TILE_ID_WIDTH-1:0]   rcv_dst_tile_id,
  input  logic [`NOU_PKT_ID_WIDTH-1:0]    rcv_pkt_id,
  output logic                            cmd_vld,
  input  logic                            cmd_rdy,
  output logic [`NOU_XOCC_CMD_WIDTH-1:0]  cmd_out,
  output logic                            q_empty
`ifdef NOU_RCV_RSP_STAT_EN
  ,
  output logic [15:0]                     rsp_sent_cnt,
  output logic [0:0]                      q_full_seen
`endif
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int TILE_W = `NOU_TILE_ID_WIDTH;
  localparam int PKT_W  = `NOU_PKT_ID_WIDTH;
  localparam int CMD_W  = `NOU_XOCC_CMD_WIDTH;
  localparam logic [$bits(`RCV_PKT_RID_RSP_TYPE)-1:0] RSP_TYPE = `RCV_PKT_RID_RSP_TYPE;
  localparam int FIELDS_W = PKT_W + 8 + TILE_W + TILE_W + $bits(RSP_TYPE);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [PKT_W-1:0]  r_pkt [DEPTH];
  logic [TILE_W-1:0] r_dst [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  logic              w_push;
  logic              w_pop;
  logic [CNT_W-1:0]  w_count_nxt;
  logic [FIELDS_W-1:0] w_cmd_fields;

  // Control outputs are pure decodes of the registered occupancy.
  assign rcv_rdy = (r_count != FULL_CNT);
  assign cmd_vld = (r_count != '0);
  assign q_empty = (r_count == '0);

  assign w_push = rcv_vld && rcv_rdy;
  assign w_pop  = cmd_vld && cmd_rdy;

  // Response command built from the head entry, zero-padded to the channel width.
  assign w_cmd_fields = {r_pkt[r_rd_ptr], 8'h00, r_dst[r_rd_ptr], local_tile_id, RSP_TYPE};
  assign cmd_out      = CMD_W'(w_cmd_fields);

  // Next occupancy: a simultaneous push and pop leaves it unchanged.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
  end

  // Entry storage; entries reset to zero so cmd_out is deterministic when empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_pkt[i] <= '0;
        r_dst[i] <= '0;
      end
    end else if (w_push) begin
      r_pkt[r_wr_ptr] <= rcv_pkt_id;
      r_dst[r_wr_ptr] <= rcv_dst_tile_id;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two; count tracks full/empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_nxt;
    end
  end

`ifdef NOU_RCV_RSP_STAT_EN
  logic [15:0] r_sent_cnt;
  logic        r_full_seen;

  assign rsp_sent_cnt   = r_sent_cnt;
  assign q_full_seen[0] = r_full_seen;

  // Saturating pop counter and sticky "queue was full" flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sent_cnt  <= '0;
      r_full_seen <= 1'b0;
    end else begin
      if (w_pop && (r_sent_cnt != 16'hFFFF)) r_sent_cnt <= r_sent_cnt + 16'd1;
      if (w_count_nxt == FULL_CNT) r_full_seen <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_rpu_rcv_rsp_queue.sv
// tb_rpu_rcv_rsp_queue
// Directed bench for rpu_rcv_rsp_queue (DEPTH=4). Inputs change 1 ns after
// the rising edge; outputs are checked there, away from the active edge.
// Build with NOU_RCV_RSP_STAT_EN defined to also exercise the statistics.

`ifndef NOU_TILE_ID_WIDTH
`define NOU_TILE_ID_WIDTH 8
`endif
`ifndef NOU_PKT_ID_WIDTH
`define NOU_PKT_ID_WIDTH 8
`endif
`ifndef NOU_XOCC_CMD_WIDTH
`define NOU_XOCC_CMD_WIDTH 64
`endif
`ifndef RCV_PKT_RID_RSP_TYPE
`define RCV_PKT_RID_RSP_TYPE 4'h6
`endif

module tb_rpu_rcv_rsp_queue;

  logic        clk;
  logic        rst;
  logic [7:0]  local_tile_id;
  logic        rcv_vld;
  logic        rcv_rdy;
  logic [7:0]  rcv_dst_tile_id;
  logic [7:0]  rcv_pkt_id;
  logic        cmd_vld;
  logic        cmd_rdy;
  logic [63:0] cmd_out;
  logic        q_empty;
`ifdef NOU_RCV_RSP_STAT_EN
  logic [15:0] rsp_sent_cnt;
  logic [0:0]  q_full_seen;
`endif

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  rpu_rcv_rsp_queue #(.DEPTH(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .local_tile_id   (local_tile_id),
    .rcv_vld         (rcv_vld),
    .rcv_rdy         (rcv_rdy),
    .rcv_dst_tile_id (rcv_dst_tile_id),
    .rcv_pkt_id      (rcv_pkt_id),
    .cmd_vld         (cmd_vld),
    .cmd_rdy         (cmd_rdy),
    .cmd_out         (cmd_out),
    .q_empty         (q_empty)
`ifdef NOU_RCV_RSP_STAT_EN
    ,
    .rsp_sent_cnt    (rsp_sent_cnt),
    .q_full_seen     (q_full_seen)
`endif
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference encoding, assembled field by field at fixed bit positions.
  function automatic logic [63:0] enc(input logic [7:0] pkt, input logic [7:0] dst);
    logic [63:0] r;
    logic [3:0]  t;
    t = `RCV_PKT_RID_RSP_TYPE;
    r = '0;
    r[3:0]   = t;
    r[11:4]  = local_tile_id;
    r[19:12] = dst;
    r[27:20] = 8'h00;
    r[35:28] = pkt;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard-tracked cycle: check pop against expected head, record push, advance.
  task automatic cycle_sb();
    if (cmd_vld && cmd_rdy) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow actual=pop expected=no_pop");
      end else begin
        chk("sb_order", cmd_out, exp_q.pop_front());
      end
    end
    if (rcv_vld && rcv_rdy) exp_q.push_back(enc(rcv_pkt_id, rcv_dst_tile_id));
    step();
  endtask

  typedef struct {
    logic       vld;
    logic [7:0] dst;
    logic [7:0] pkt;
    logic       rdy;
    logic       e_rcv_rdy;
    logic       e_cmd_vld;
    logic [7:0] e_pkt;
    logic [7:0] e_dst;
  } vec_t;

  vec_t vt[13];

  initial begin
    // Single event, then fill with backpressure, held 5th event, ordered drain.
    vt[0]  = '{1'b1, 8'h05, 8'h2A, 1'b1, 1'b1, 1'b1, 8'h2A, 8'h05};
    vt[1]  = '{1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00};
    vt[2]  = '{1'b1, 8'h11, 8'h01, 1'b0, 1'b1, 1'b1, 8'h01, 8'h11};
    vt[3]  = '{1'b1, 8'h12, 8'h02, 1'b0, 1'b1, 1'b1, 8'h01, 8'h11};
    vt[4]  = '{1'b1, 8'h13, 8'h03, 1'b0, 1'b1, 1'b1, 8'h01, 8'h11};
    vt[5]  = '{1'b1, 8'h14, 8'h04, 1'b0, 1'b0, 1'b1, 8'h01, 8'h11};
    vt[6]  = '{1'b1, 8'h15, 8'h05, 1'b0, 1'b0, 1'b1, 8'h01, 8'h11};
    vt[7]  = '{1'b1, 8'h15, 8'h05, 1'b1, 1'b1, 1'b1, 8'h02, 8'h12};
    vt[8]  = '{1'b1, 8'h15, 8'h05, 1'b0, 1'b0, 1'b1, 8'h02, 8'h12};
    vt[9]  = '{1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 8'h03, 8'h13};
    vt[10] = '{1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 8'h04, 8'h14};
    vt[11] = '{1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 8'h05, 8'h15};
    vt[12] = '{1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00};

    rst = 1'b1;
    local_tile_id = 8'h03;
    rcv_vld = 1'b0;
    rcv_dst_tile_id = '0;
    rcv_pkt_id = '0;
    cmd_rdy = 1'b0;
    step();
    step();

    // Reset state
    chk("rst_rcv_rdy", rcv_rdy, 1'b1);
    chk("rst_cmd_vld", cmd_vld, 1'b0);
    chk("rst_q_empty", q_empty, 1'b1);
    chk("rst_cmd_out", cmd_out, enc(8'h00, 8'h00));
`ifdef NOU_RCV_RSP_STAT_EN
    chk("rst_sent_cnt", rsp_sent_cnt, 16'h0000);
    chk("rst_full_seen", q_full_seen, 1'b0);
`endif
    rst = 1'b0;
    step();

    // Table-driven vectors: outputs expected after each edge
    for (int i = 0; i < 13; i++) begin
      rcv_vld = vt[i].vld;
      rcv_dst_tile_id = vt[i].dst;
      rcv_pkt_id = vt[i].pkt;
      cmd_rdy = vt[i].rdy;
      step();
      chk($sformatf("vec%0d_rcv_rdy", i), rcv_rdy, vt[i].e_rcv_rdy);
      chk($sformatf("vec%0d_cmd_vld", i), cmd_vld, vt[i].e_cmd_vld);
      chk($sformatf("vec%0d_q_empty", i), q_empty, !vt[i].e_cmd_vld);
      if (vt[i].e_cmd_vld)
        chk($sformatf("vec%0d_cmd_out", i), cmd_out, enc(vt[i].e_pkt, vt[i].e_dst));
    end
    rcv_vld = 1'b0;
    cmd_rdy = 1'b0;
`ifdef NOU_RCV_RSP_STAT_EN
    chk("stat_full_seen_after_drain", q_full_seen, 1'b1);
    chk("stat_sent_cnt_table", rsp_sent_cnt, 16'd6);
`endif

    // Simultaneous push/pop at count 2 for 10 cycles, with pointer wrap
    exp_q.delete();
    for (int i = 0; i < 2; i++) begin
      rcv_vld = 1'b1;
      rcv_pkt_id = 8'h30 + 8'(i);
      rcv_dst_tile_id = 8'h60 + 8'(i);
      cmd_rdy = 1'b0;
      cycle_sb();
    end
    for (int i = 0; i < 10; i++) begin
      rcv_vld = 1'b1;
      rcv_pkt_id = 8'h40 + 8'(i);
      rcv_dst_tile_id = 8'h70 + 8'(i);
      cmd_rdy = 1'b1;
      cycle_sb();
    end
    chk("pp_rcv_rdy", rcv_rdy, 1'b1);
    chk("pp_cmd_vld", cmd_vld, 1'b1);
    rcv_vld = 1'b0;
    cycle_sb();
    chk("pp_after_one_pop_q_empty", q_empty, 1'b0);
    cycle_sb();
    chk("pp_after_two_pops_q_empty", q_empty, 1'b1);
    chk("pp_sb_drained", 64'(exp_q.size()), 64'd0);

    // Random backpressure with hold-stability check, 100 events
    begin
      int sent = 0;
      int got = 0;
      logic prev_stall = 1'b0;
      logic [63:0] prev_out = '0;
      logic [31:0] seed_dummy;
      seed_dummy = $urandom(32'h0000_5eed);
      exp_q.delete();
      cmd_rdy = 1'b0;
      for (int cyc = 0; cyc < 3000 && got < 100; cyc++) begin
        if (!rcv_vld && sent < 100 && $urandom_range(0, 3) != 0) begin
          rcv_vld = 1'b1;
          rcv_pkt_id = 8'(sent);
          rcv_dst_tile_id = 8'(sent * 3);
        end
        cmd_rdy = 1'($urandom_range(0, 1));
        if (prev_stall) begin
          chk("hold_cmd_vld", cmd_vld, 1'b1);
          chk("hold_cmd_out", cmd_out, prev_out);
        end
        if (cmd_vld && cmd_rdy) got++;
        if (rcv_vld && rcv_rdy) sent++;
        prev_stall = cmd_vld && !cmd_rdy;
        prev_out = cmd_out;
        begin
          logic accepted;
          accepted = rcv_vld && rcv_rdy;
          cycle_sb();
          if (accepted) rcv_vld = 1'b0;
        end
      end
      chk("bp_all_received", 64'(got), 64'd100);
      chk("bp_sb_drained", 64'(exp_q.size()), 64'd0);
      rcv_vld = 1'b0;
      cmd_rdy = 1'b0;
    end

    // Reset mid-drain with 3 entries queued
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      rcv_vld = 1'b1;
      rcv_pkt_id = 8'hA0 + 8'(i);
      rcv_dst_tile_id = 8'hB0 + 8'(i);
      cmd_rdy = 1'b0;
      step();
    end
    rcv_vld = 1'b0;
    cmd_rdy = 1'b1;
    step();
    chk("mid_pre_rst_cmd_out", cmd_out, enc(8'hA1, 8'hB1));
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_cmd_vld", cmd_vld, 1'b0);
    chk("mid_rst_rcv_rdy", rcv_rdy, 1'b1);
    chk("mid_rst_q_empty", q_empty, 1'b1);
    cmd_rdy = 1'b0;
    step();
    rst = 1'b0;
    local_tile_id = 8'h7E;
    step();
    rcv_vld = 1'b1;
    rcv_pkt_id = 8'h11;
    rcv_dst_tile_id = 8'h22;
    step();
    rcv_vld = 1'b0;
    chk("post_rst_cmd_vld", cmd_vld, 1'b1);
    chk("post_rst_first_out", cmd_out, enc(8'h11, 8'h22));
    cmd_rdy = 1'b1;
    step();
    chk("post_rst_q_empty", q_empty, 1'b1);
    cmd_rdy = 1'b0;

`ifdef NOU_RCV_RSP_STAT_EN
    // Saturation of the pop counter; no fill since the last reset
    chk("stat_sent_after_rst", rsp_sent_cnt, 16'd1);
    chk("stat_full_cleared", q_full_seen, 1'b0);
    rcv_vld = 1'b1;
    step();
    cmd_rdy = 1'b1;
    for (int i = 0; i < 99; i++) step();
    chk("stat_sent_100", rsp_sent_cnt, 16'd100);
    for (int i = 0; i < 69950; i++) step();
    chk("stat_sent_sat", rsp_sent_cnt, 16'hFFFF);
    rcv_vld = 1'b0;
    step();
    chk("stat_sent_sat_hold", rsp_sent_cnt, 16'hFFFF);
    cmd_rdy = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
